// File: rtl/alu16_pkg.sv
// Shared ALU16 types: compare FSM states, nibble width and the lt/eq/gt result layout
// that the ALU flag logic expects.
package alu16_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cmp_state_t;

  // Bit order {lt, eq, gt} is what the flag logic and branch-compare path decode.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};

endpackage

// File: rtl/seq_cmp16_if.sv
// Start/done handshake, operands and registered result of the sequential comparator.
interface seq_cmp16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/seq_cmp16_comp4.sv
// Existing 4-bit unsigned magnitude slice shared with the ALU16 datapath.
module comp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);
  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

// File: rtl/seq_cmp16.sv
// Multi-cycle magnitude comparator: walks the operands one nibble per cycle, MSB first,
// through a single comp4 slice and stops on the first unequal nibble.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last compare
// RUN   | comparing nibble idx_q; decides when the slice differs or idx_q == 0
module seq_cmp16
  import alu16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  seq_cmp16_if.slave  bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

  cmp_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  cmp_res_t         res_q, res_d;
  logic             done_q, done_d;

  logic [NIB_W-1:0] nib_a, nib_b;
  logic             s_lt, s_eq, s_gt;
  logic             decide;

  // Offset-binary on the top nibble lets the unsigned slice order signed operands.
  always_comb begin
    nib_a = a_q[idx_q*NIB_W +: NIB_W];
    nib_b = b_q[idx_q*NIB_W +: NIB_W];
    if (sgn_q && (idx_q == IDX_TOP)) begin
      nib_a[NIB_W-1] = ~nib_a[NIB_W-1];
      nib_b[NIB_W-1] = ~nib_b[NIB_W-1];
    end
  end

  comp4 u_comp4 (
    .a  (nib_a),
    .b  (nib_b),
    .lt (s_lt),
    .eq (s_eq),
    .gt (s_gt)
  );

  assign decide = !s_eq || (idx_q == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.signed_mode;
          idx_d   = IDX_TOP;
          state_d = RUN;
        end
      end
      RUN: begin
        if (decide) begin
          res_d   = '{lt: s_lt, eq: s_eq, gt: s_gt};
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      res_q   <= RES_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.lt   = res_q.lt;
  assign bus.eq   = res_q.eq;
  assign bus.gt   = res_q.gt;

endmodule

// File: doc/seq_cmp16.md
# seq_cmp16

Multi-cycle 16-bit magnitude comparator that walks operands nibble by nibble, MSB first, through a single `comp4` slice. It sits downstream of `comp4` in the ALU16 datapath. It consumes the slice's `lt`/`eq`/`gt` each cycle and terminates early on the first unequal nibble. The registered lt/eq/gt result feeds the ALU flag logic and branch-compare path, with a start/done handshake.

## Interface
- `WIDTH`, 16, operand width; must be a multiple of 4; `NIB = WIDTH/4` nibbles.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request compare; sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement compare; 0 = unsigned; latched with `start`.
- `a`  in  WIDTH  operand A; latched with `start`.
- `b`  in  WIDTH  operand B; latched with `start`.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse when the result registers update.
- `lt`  out  1  registered A<B.
- `eq`  out  1  registered A==B.
- `gt`  out  1  registered A>B.

## Operation
- States are IDLE and RUN.
  - IDLE -> RUN on `start`=1.
  - RUN -> IDLE on decision.
- On accept:
  - Latch `a`, `b` and `signed_mode`.
  - Set nibble index `idx = NIB-1`.
- In RUN, `comp4` is driven combinationally with `a_r[4*idx +: 4]` and `b_r[4*idx +: 4]`.
  - In signed mode only, bit 3 of both operands is inverted on the MSB nibble (`idx == NIB-1`).
  - This is offset-binary mapping, so an unsigned slice compare gives the signed ordering.
- Decision rule: the slice reports `eq`=0, or `idx`=0.
  - On decision, register the slice lt/eq/gt into the outputs.
  - Assert `done` for one cycle.
  - Return to IDLE.
- Otherwise decrement `idx` and stay in RUN.
- Exactly one of `lt`/`eq`/`gt` is high after any completed compare.
- Outputs hold their value until the next `done`.
- `start` while `busy`=1 is ignored. Operands in flight are unaffected.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE.
- Operand inputs are don't-care except in the `start` accept cycle.
- Reset values:
  - state IDLE, `idx = NIB-1`
  - `busy`=0, `done`=0
  - `lt`=0, `eq`=0, `gt`=0 (no valid result until the first `done`)
- `rst` asserted mid-RUN aborts immediately to the reset values. No `done` is emitted.

## Timing
- Edge E0: `start` sampled in IDLE. `busy`=1 after E0.
- Edge E_k (k = 1..NIB): nibble `NIB-k` evaluated.
  - If decided, after E_k `done`=1, results valid, `busy`=0.
- Latency from the `start` edge to the `done`-high cycle is 1..NIB cycles.
  - It equals 1 + the number of leading equal nibbles, capped at NIB.
- Equal operands always take NIB cycles.
- Back-to-back: with `start` held high, a new compare begins on the edge after `done`. The throughput gap is zero idle cycles.
- `done` is never high for two consecutive cycles on the same operation.
- Critical path: operand mux by `idx` -> sign-bit XOR -> `comp4` -> result registers. This is a single cycle at the ALU clock.

## Structure
- Shared package `alu16_pkg` holds:
  - state enum `cmp_state_t` {IDLE, RUN}
  - constant `NIB_W = 4`
  - the lt/eq/gt encoding order used by ALU flag logic
- Sub-module: one instance of the existing `comp4`.
  - Do not re-implement nibble compare logic.
- Nibble select and the offset-binary XOR live in `seq_cmp16`.

## Test plan
- Unsigned, a=0x1234, b=0x1235, start pulse -> `busy` for 4 cycles; `done` 4 cycles after start; lt=1 eq=0 gt=0.
- a=0xA000, b=0x1000 -> unsigned: gt=1, latency 1; signed: lt=1, latency 1.
- a=b=0xFFFF, both modes -> eq=1, latency 4. Signed a=0xFFFF, b=0x0000 -> lt=1, latency 1.
- Start a=0x0050, b=0x0040. Pulse `start` with a=0x0000, b=0xFFFF during RUN -> ignored; `done` after 3 cycles with gt=1.
  - Then hold `start`=1 through `done` with a=0x0001, b=0x0001 -> second compare accepted on the `done` cycle; eq=1 four cycles later.
- `rst` asserted on the second RUN cycle of a 0x1111 vs 0x1112 compare -> outputs immediately busy=0, done=0, lt=eq=gt=0.
  - No `done` follows.
  - A fresh start after release completes normally with lt=1.
